vram_hex_writer: RTL
====================

Name: vram_hex_writer

Overview:
- Parametrised successor to the single-purpose debug-to-VRAM writer in the board top.
- Takes a snapshot of NCH packed 32-bit debug channels and renders each channel into the text VRAM as 8 upper-case ASCII hex digits plus padding.
- Channels are laid out on a configurable grid.
- Sits between the CPU debug buses (registers, pipeline PCs and instructions, ALU values) and the VRAM write port that feeds the VGA/font path. Runs on the VRAM clock domain.

Parameters:
- NCH, 16, number of 32-bit channels
- COLS, 80, characters per text row
- ADDR_W, 13, VRAM address width
- ROW0, 0, first text row used
- COL0, 0, first text column used
- CH_PER_ROW, 4, channels per text row
- FIELD_W, 10, characters per channel field; must be >= 8; padding is FIELD_W-8 spaces

Ports:
- clk  in  1  VRAM-side clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request one render pass (level sampled each cycle)
- data_in  in  NCH*32  channel k occupies bits [32k+31:32k]
- vram_we  out  1  VRAM write enable
- vram_write_addr  out  ADDR_W  VRAM write address
- vram_data_in  out  8  character written
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse when a pass completes

Behaviour:
- Reset values: vram_we=0, vram_write_addr=0, vram_data_in=0, busy=0, done=0. Reset also clears the snapshot, the previous-snapshot register and the pending flag.
- All outputs are registered.
- FSM states: IDLE, WRITE.
- IDLE, start=1 at edge E0:
  - snapshot <= data_in
  - busy=1 from E0
  - state -> WRITE
- WRITE emits exactly N = NCH*FIELD_W writes:
  - vram_we=1 on the N consecutive cycles following E1.
  - Order: channel 0 to NCH-1; within a channel, field position 0 to FIELD_W-1.
  - Positions 0-7 carry nibbles [31:28] down to [3:0].
  - Positions 8 and above carry 0x20 (space).
- Hex encoding: 0-9 map to 0x30-0x39; A-F map to 0x41-0x46; bit 7 is 0 unless the optional feature sets it.
- Address for channel k, position p:
  - (ROW0 + k/CH_PER_ROW)*COLS + COL0 + (k%CH_PER_ROW)*FIELD_W + p, truncated to ADDR_W.
  - Generated incrementally (row base and column counters); no divider.
- done pulses for 1 cycle in the cycle immediately after the last vram_we cycle.
- End of pass, no pending request: busy falls in the same cycle done rises; state -> IDLE.
- start while busy:
  - Sets pending; multiple requests merge into one.
  - At end of pass, if pending: clear pending, take a new snapshot, start the next pass with no gap.
  - busy stays 1 throughout; done still pulses once per pass.
- data_in changes during a pass have no effect; the snapshot is used throughout.
- rst mid-pass:
  - Next cycle vram_we=0, busy=0, no done pulse.
  - Partially written VRAM contents are left as they are.
- Legal-parameter conditions are checked only by simulation assertions, not in hardware:
  - COL0 + CH_PER_ROW*FIELD_W <= COLS
  - Last address < 2^ADDR_W
- Write bandwidth: one character per clock, no backpressure; the VRAM port is always ready.

Optional Feature:
- Macro: VRAM_HEX_WRITER_CHANGE_HILITE_EN.
- With the macro:
  - At each snapshot the prior snapshot is copied to the previous-snapshot register.
  - Every character of channel k (digits and padding) is written with bit 7 set if the channel differs from its previous value. The font path ignores bit 7, so the renderer can use it as inverse video.
  - The first pass after reset compares against zero.
- Without the macro: no previous-snapshot register; bit 7 is always 0.

Test Plan:
- Defaults; ch0=0x1234ABCD; pulse start -> writes to addr 0-9 with data 0x31,0x32,0x33,0x34,0x41,0x42,0x43,0x44,0x20,0x20.
- ch5=0xDEADBEEF -> addr 90-97 (row 1, col 10) receive 0x44,0x45,0x41,0x44,0x42,0x45,0x45,0x46.
- Single start -> exactly 160 vram_we cycles; done pulses once, in the cycle after the last write; busy high for 161 cycles.
- Change ch0 to 0xFFFFFFFF during a pass -> that pass still writes 0x1234ABCD; raise start mid-pass -> second pass back-to-back, busy continuous, two done pulses, second pass shows 0x46 (F) characters.
- Assert rst after the 37th write -> next cycle vram_we=0, busy=0, no done; a fresh start then produces a full 160-write pass.
- With VRAM_HEX_WRITER_CHANGE_HILITE_EN: pass 1 with ch3=0, ch7=5 -> ch7 chars have bit 7=1, ch3 chars 0; pass 2 with only ch3 changed -> only ch3 chars have bit 7=1.

Source files
------------

// File: rtl/vram_hex_writer.sv
// vram_hex_writer: renders NCH 32-bit debug channels into text VRAM as
// upper-case hex fields laid out on a grid, one character per clock.
// Optional build macro: VRAM_HEX_WRITER_CHANGE_HILITE_EN sets bit 7 on every
// character of a channel whose value changed since the previous snapshot.
//
// state | meaning
// IDLE  | waiting for start
// WRITE | emitting characters; fin_q marks the closing done cycle
module vram_hex_writer #(
  parameter int NCH        = 16,
  parameter int COLS       = 80,
  parameter int ADDR_W     = 13,
  parameter int ROW0       = 0,
  parameter int COL0       = 0,
  parameter int CH_PER_ROW = 4,
  parameter int FIELD_W    = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NCH*32-1:0]   data_in,
  output logic                vram_we,
  output logic [ADDR_W-1:0]   vram_write_addr,
  output logic [7:0]          vram_data_in,
  output logic                busy,
  output logic                done
);

  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int POS_W  = $clog2(FIELD_W + 1);
  localparam int SLOT_W = (CH_PER_ROW > 1) ? $clog2(CH_PER_ROW) : 1;
  localparam int LAST_ADDR = (ROW0 + (NCH - 1) / CH_PER_ROW) * COLS + COL0
                             + ((NCH - 1) % CH_PER_ROW) * FIELD_W + FIELD_W - 1;
  localparam logic [ADDR_W-1:0] ROW_BASE0 = ADDR_W'(ROW0 * COLS);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] COL0_A    = ADDR_W'(COL0);

  // Parameter legality is an elaboration-time concern only.
  if (FIELD_W < 8) begin : g_bad_field
    $error("vram_hex_writer: FIELD_W must be at least 8");
  end
  if (COL0 + CH_PER_ROW * FIELD_W > COLS) begin : g_bad_cols
    $error("vram_hex_writer: channel row does not fit in COLS");
  end
  if (LAST_ADDR >= (1 << ADDR_W)) begin : g_bad_addr
    $error("vram_hex_writer: last address exceeds ADDR_W");
  end

  typedef enum logic {IDLE, WRITE} state_t;

  state_t              state_q, state_d;
  logic [NCH*32-1:0]   snap_q, snap_d;
  logic                pend_q, pend_d;
  logic                fin_q, fin_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                load_c;
  logic [31:0]         ch_word;
  logic [3:0]          nib_c;
  logic [7:0]          char_c;
`ifdef VRAM_HEX_WRITER_CHANGE_HILITE_EN
  logic [NCH*32-1:0]   prev_q, prev_d;
  logic [31:0]         prev_word;
`endif

  // Select the current channel word and encode the current field character.
  always_comb begin
    ch_word = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_q == CH_W'(k)) ch_word = snap_q[32*k +: 32];
    end
    nib_c = ch_word[{~pos_q[2:0], 2'b00} +: 4];
    if (pos_q > POS_W'(7))    char_c = 8'h20;
    else if (nib_c < 4'd10)   char_c = {4'h3, nib_c};
    else                      char_c = 8'h37 + {4'h0, nib_c};
`ifdef VRAM_HEX_WRITER_CHANGE_HILITE_EN
    prev_word = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_q == CH_W'(k)) prev_word = prev_q[32*k +: 32];
    end
    char_c[7] = (ch_word != prev_word);
`endif
  end

  // Next-state, counter walk and registered output values.
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    pend_d     = pend_q;
    fin_d      = fin_q;
    ch_d       = ch_q;
    pos_d      = pos_q;
    slot_d     = slot_q;
    row_base_d = row_base_q;
    cur_addr_d = cur_addr_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load_c     = 1'b0;
`ifdef VRAM_HEX_WRITER_CHANGE_HILITE_EN
    prev_d     = prev_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) load_c = 1'b1;
      end
      WRITE: begin
        if (start) pend_d = 1'b1;
        if (!fin_q) begin
          we_d       = 1'b1;
          addr_d     = cur_addr_q;
          data_d     = char_c;
          cur_addr_d = cur_addr_q + 1'b1;
          if (pos_q == POS_W'(FIELD_W - 1)) begin
            pos_d = '0;
            if (ch_q == CH_W'(NCH - 1)) begin
              fin_d = 1'b1;
            end else begin
              ch_d = ch_q + 1'b1;
              if (slot_q == SLOT_W'(CH_PER_ROW - 1)) begin
                slot_d     = '0;
                row_base_d = row_base_q + COLS_A;
                cur_addr_d = row_base_q + COLS_A + COL0_A;
              end else begin
                slot_d = slot_q + 1'b1;
              end
            end
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end else begin
          done_d = 1'b1;
          pend_d = 1'b0;
          if (pend_q || start) begin
            load_c = 1'b1;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_c) begin
      snap_d     = data_in;
      busy_d     = 1'b1;
      state_d    = WRITE;
      fin_d      = 1'b0;
      ch_d       = '0;
      pos_d      = '0;
      slot_d     = '0;
      row_base_d = ROW_BASE0;
      cur_addr_d = ROW_BASE0 + COL0_A;
`ifdef VRAM_HEX_WRITER_CHANGE_HILITE_EN
      prev_d     = snap_q;
`endif
    end
  end

  // State, snapshot and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      pend_q     <= 1'b0;
      fin_q      <= 1'b0;
      ch_q       <= '0;
      pos_q      <= '0;
      slot_q     <= '0;
      row_base_q <= '0;
      cur_addr_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef VRAM_HEX_WRITER_CHANGE_HILITE_EN
      prev_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      pend_q     <= pend_d;
      fin_q      <= fin_d;
      ch_q       <= ch_d;
      pos_q      <= pos_d;
      slot_q     <= slot_d;
      row_base_q <= row_base_d;
      cur_addr_q <= cur_addr_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef VRAM_HEX_WRITER_CHANGE_HILITE_EN
      prev_q     <= prev_d;
`endif
    end
  end

  assign vram_we         = we_q;
  assign vram_write_addr = addr_q;
  assign vram_data_in    = data_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
